lane_reg_file: RTL and testbench

Parametrised multi-lane register file: each entry holds LANES lanes of DATA_WIDTH bits. One synchronous write port with per-lane write mask, RD_PORTS independent asynchronous lane-select read ports, and a built-in sequential clear engine that zeroes the array one entry per cycle. It is the general-purpose register storage for datapaths that write wide words and consume narrow lanes.

---
 rtl/lane_reg_file_pkg.sv | 13 +
 rtl/rf_clear_seq.sv | 52 +++++
 rtl/lane_reg_file.sv | 83 ++++++++
 tb/tb_lane_reg_file.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_reg_file_pkg.sv
// lane_reg_file_pkg: shared types and lane-slicing helper for the lane register file
package lane_reg_file_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: sweeps every entry once, one per cycle, and reports busy/done
module rf_clear_seq
  import lane_reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  busy_q;
  logic                  done_q;

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign clr_en   = state_q == CLEAR;
  assign clr_addr = ptr_q;

  // Sweep FSM: requests are only honoured from IDLE, so a sweep never restarts early
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      done_q <= 1'b0;
      if (clr_req) begin
        state_q <= CLEAR;
        ptr_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      ptr_q <= ptr_q + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lane_reg_file.sv
// lane_reg_file: multi-lane register file with masked writes, lane-select reads and a clear sweep
module lane_reg_file
  import lane_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int RD_PORTS   = 2,
  parameter int BYPASS     = 0,
  localparam int LANE_W    = LANES > 1 ? $clog2(LANES) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           w_en,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [LANES-1:0]               w_lane_mask,
  input  logic [LANES*DATA_WIDTH-1:0]    w_data,
  output logic                           w_ready,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] r_addr,
  input  logic [RD_PORTS*LANE_W-1:0]     r_lane,
  output logic [RD_PORTS*DATA_WIDTH-1:0] r_data,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic                           clr_done
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int WORD_W = LANES * DATA_WIDTH;

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [WORD_W-1:0]     word_d;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  w_fire;

  rf_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  // Writes are refused, not queued, while the sweep owns the array
  assign w_ready = !clr_busy;
  assign w_fire  = w_en && w_ready;

  // Merge masked-in lanes of the incoming word over the stored entry
  always_comb begin
    word_d = mem_q[w_addr];
    for (int l = 0; l < LANES; l++)
      if (w_lane_mask[l])
        word_d[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] = w_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH];
  end

  // Array storage: clear sweep and accepted writes never coincide since w_ready drops while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (w_fire) begin
      mem_q[w_addr] <= word_d;
    end
  end

  // Lane-select read muxes; unmatched lane codes fall through to zero, optional write forwarding
  always_comb begin
    r_data = '0;
    for (int p = 0; p < RD_PORTS; p++)
      for (int l = 0; l < LANES; l++)
        if (r_lane[p*LANE_W +: LANE_W] == LANE_W'(l))
          r_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (BYPASS != 0 && w_fire && w_addr == r_addr[p*ADDR_WIDTH +: ADDR_WIDTH] && w_lane_mask[l])
              ? w_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]
              : mem_q[r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]][lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_lane_reg_file.sv
// tb_lane_reg_file: scoreboard-driven bench for the default file and a bypassing 3-lane variant
module tb_lane_reg_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_en;
  logic [1:0]  w_addr;
  logic [1:0]  w_lane_mask;
  logic [15:0] w_data;
  logic        w_ready;
  logic [3:0]  r_addr;
  logic [1:0]  r_lane;
  logic [15:0] r_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  logic        b_w_en;
  logic [1:0]  b_w_addr;
  logic [2:0]  b_w_mask;
  logic [23:0] b_w_data;
  logic        b_w_ready;
  logic [1:0]  b_r_addr;
  logic [1:0]  b_r_lane;
  logic [7:0]  b_r_data;
  logic        b_clr_req;
  logic        b_clr_busy;
  logic        b_clr_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e;
  logic [15:0] mdl[4];

  always #10 clk = ~clk;

  lane_reg_file dut (
    .clk(clk), .reset_n(reset_n), .w_en(w_en), .w_addr(w_addr), .w_lane_mask(w_lane_mask),
    .w_data(w_data), .w_ready(w_ready), .r_addr(r_addr), .r_lane(r_lane), .r_data(r_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  lane_reg_file #(.LANES(3), .RD_PORTS(1), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .w_en(b_w_en), .w_addr(b_w_addr), .w_lane_mask(b_w_mask),
    .w_data(b_w_data), .w_ready(b_w_ready), .r_addr(b_r_addr), .r_lane(b_r_lane), .r_data(b_r_data),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_write(input logic [1:0] a, input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    w_en = 1'b1; w_addr = a; w_lane_mask = m; w_data = d;
    @(posedge clk); #1;
    w_en = 1'b0; w_lane_mask = 2'b00;
    for (int l = 0; l < 2; l++) if (m[l]) mdl[a][l*8 +: 8] = d[l*8 +: 8];
  endtask

  // port0 reads lane l0 of a, port1 reads lane l1 of a; expectations come from the model
  task automatic drive_rd(input logic [1:0] a, input logic l0, input logic l1);
    r_addr = {a, a};
    r_lane = {l1, l0};
    exp_q.push_back(mdl[a][l0*8 +: 8]);
    exp_q.push_back(mdl[a][l1*8 +: 8]);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
    #1;
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL reset_w_ready got %b exp 1", w_ready); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", clr_busy); end
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", clr_done); end
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < 2; l++) begin
        drive_rd(2'(a), 1'(l), 1'(l));
        e = exp_q.pop_front(); n_cmp++;
        if (r_data[7:0] !== e) begin n_bad++; $display("FAIL reset_rd a=%0d l=%0d p0 got %h exp %h", a, l, r_data[7:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (r_data[15:8] !== e) begin n_bad++; $display("FAIL reset_rd a=%0d l=%0d p1 got %h exp %h", a, l, r_data[15:8], e); end
      end
    b_r_addr = 2'd3; b_r_lane = 2'd2; #1;
    n_cmp++; if (b_r_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_b got %h exp 00", b_r_data); end
  endtask

  task automatic test_write;
    do_write(2'd2, 2'b11, 16'hBEEF);
    do_write(2'd2, 2'b01, 16'h1234);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'h34);
    drive_rd(2'd2, 1'b1, 1'b0);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL write_merge p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL write_merge p1 got %h exp %h", r_data[15:8], e); end
    do_write(2'd2, 2'b00, 16'hFFFF);
    drive_rd(2'd2, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL write_mask0 p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL write_mask0 p1 got %h exp %h", r_data[15:8], e); end
    do_write(2'd0, 2'b11, 16'($urandom));
    do_write(2'd1, 2'b10, 16'($urandom));
    do_write(2'd3, 2'b01, 16'($urandom));
    for (int a = 0; a < 4; a++) begin
      drive_rd(2'(a), 1'b0, 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (r_data[7:0] !== e) begin n_bad++; $display("FAIL write_rand a=%0d p0 got %h exp %h", a, r_data[7:0], e); end
      e = exp_q.pop_front(); n_cmp++;
      if (r_data[15:8] !== e) begin n_bad++; $display("FAIL write_rand a=%0d p1 got %h exp %h", a, r_data[15:8], e); end
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    b_w_en = 1'b1; b_w_addr = 2'd1; b_w_mask = 3'b010; b_w_data = 24'h00A55A;
    b_r_addr = 2'd1; b_r_lane = 2'd1;
    w_en = 1'b1; w_addr = 2'd1; w_lane_mask = 2'b10; w_data = 16'hA55A;
    r_addr = {2'd1, 2'd1}; r_lane = 2'b01;
    exp_q.push_back(8'hA5);
    exp_q.push_back(mdl[1][15:8]);
    exp_q.push_back(mdl[1][7:0]);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (b_r_data !== e) begin n_bad++; $display("FAIL bypass_fwd got %h exp %h", b_r_data, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL nobypass_old p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL nobypass_old p1 got %h exp %h", r_data[15:8], e); end
    b_r_lane = 2'd0;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (b_r_data !== e) begin n_bad++; $display("FAIL bypass_unmasked got %h exp %h", b_r_data, e); end
    @(posedge clk); #1;
    b_w_en = 1'b0; w_en = 1'b0;
    mdl[1][15:8] = 8'hA5;
    b_r_lane = 2'd1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(mdl[1][15:8]);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (b_r_data !== e) begin n_bad++; $display("FAIL bypass_stored got %h exp %h", b_r_data, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL nobypass_after_edge got %h exp %h", r_data[7:0], e); end
  endtask

  task automatic test_lane_oob;
    logic [7:0] lane_exp [4];
    lane_exp[0] = 8'hA1; lane_exp[1] = 8'hB2; lane_exp[2] = 8'hC3; lane_exp[3] = 8'h00;
    @(negedge clk);
    b_w_en = 1'b1; b_w_addr = 2'd2; b_w_mask = 3'b111; b_w_data = 24'hC3B2A1;
    @(posedge clk); #1;
    b_w_en = 1'b0;
    b_r_addr = 2'd2;
    for (int l = 0; l < 4; l++) begin
      b_r_lane = 2'(l);
      exp_q.push_back(lane_exp[l]);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (b_r_data !== e) begin n_bad++; $display("FAIL lane_sel l=%0d got %h exp %h", l, b_r_data, e); end
    end
  endtask

  task automatic test_clear;
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int a = 0; a < 4; a++) do_write(2'(a), 2'b11, 16'hFFFF);
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j >= 1 && j <= 4) mdl[j-1] = 16'h0;
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      n_cmp++;
      if (clr_busy !== (j <= 3)) begin n_bad++; $display("FAIL clear_busy j=%0d got %b exp %b", j, clr_busy, j <= 3); end
      n_cmp++;
      if (w_ready !== (j > 3)) begin n_bad++; $display("FAIL clear_w_ready j=%0d got %b exp %b", j, w_ready, j > 3); end
      for (int a = 0; a < 4; a++) begin
        drive_rd(2'(a), 1'b1, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (r_data[7:0] !== e) begin n_bad++; $display("FAIL clear_rd j=%0d a=%0d p0 got %h exp %h", j, a, r_data[7:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (r_data[15:8] !== e) begin n_bad++; $display("FAIL clear_rd j=%0d a=%0d p1 got %h exp %h", j, a, r_data[15:8], e); end
      end
      if (j < 5) begin @(posedge clk); #1; end
    end
    n_cmp++; if (busy_cnt != 4) begin n_bad++; $display("FAIL clear_busy_cycles got %0d exp 4", busy_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clear_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_write_busy;
    logic got = 1'b0;
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    w_en = 1'b1; w_addr = 2'd0; w_lane_mask = 2'b11; w_data = 16'h5A5A;
    #1;
    n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL busy_w_ready got %b exp 0", w_ready); end
    @(posedge clk); #1;
    w_en = 1'b0; w_lane_mask = 2'b00;
    for (int c = 0; c < 10 && !got; c++) begin @(posedge clk); #1; got = clr_done; end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL busy_done_wait got %b exp 1", got); end
    drive_rd(2'd0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL busy_drop p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL busy_drop p1 got %h exp %h", r_data[15:8], e); end
  endtask

  task automatic test_concurrent;
    logic got = 1'b0;
    @(negedge clk);
    w_en = 1'b1; w_addr = 2'd2; w_lane_mask = 2'b11; w_data = 16'h7777; clr_req = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0; w_lane_mask = 2'b00; clr_req = 1'b0;
    mdl[2] = 16'h7777;
    n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL conc_busy got %b exp 1", clr_busy); end
    drive_rd(2'd2, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL conc_stored p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL conc_stored p1 got %h exp %h", r_data[15:8], e); end
    for (int c = 0; c < 10 && !got; c++) begin @(posedge clk); #1; got = clr_done; end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL conc_done_wait got %b exp 1", got); end
    for (int a = 0; a < 4; a++) mdl[a] = 16'h0;
    drive_rd(2'd2, 1'b1, 1'b0);
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL conc_erased p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL conc_erased p1 got %h exp %h", r_data[15:8], e); end
  endtask

  task automatic test_back_to_back;
    int busy_cnt = 0;
    int done_cnt = 0;
    int ovl = 0;
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 12; j++) begin
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      ovl += int'(clr_busy && clr_done);
      if (j == 5) clr_req = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt); end
    n_cmp++; if (busy_cnt != 8) begin n_bad++; $display("FAIL b2b_busy_cycles got %0d exp 8", busy_cnt); end
    n_cmp++; if (ovl != 0) begin n_bad++; $display("FAIL b2b_overlap got %0d exp 0", ovl); end
  endtask

  task automatic test_reset_mid;
    int done_cnt = 0;
    for (int a = 0; a < 4; a++) do_write(2'(a), 2'b11, 16'h1111 * 16'(a + 1));
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    drive_rd(2'd3, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[7:0] !== e) begin n_bad++; $display("FAIL mid_pre p0 got %h exp %h", r_data[7:0], e); end
    e = exp_q.pop_front(); n_cmp++;
    if (r_data[15:8] !== e) begin n_bad++; $display("FAIL mid_pre p1 got %h exp %h", r_data[15:8], e); end
    reset_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) mdl[a] = 16'h0;
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b exp 0", clr_busy); end
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL mid_w_ready got %b exp 1", w_ready); end
    for (int a = 0; a < 4; a++) begin
      drive_rd(2'(a), 1'b0, 1'b1);
      e = exp_q.pop_front(); n_cmp++;
      if (r_data[7:0] !== e) begin n_bad++; $display("FAIL mid_rd a=%0d p0 got %h exp %h", a, r_data[7:0], e); end
      e = exp_q.pop_front(); n_cmp++;
      if (r_data[15:8] !== e) begin n_bad++; $display("FAIL mid_rd a=%0d p1 got %h exp %h", a, r_data[15:8], e); end
    end
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      done_cnt += int'(clr_done || clr_busy);
    end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL mid_no_done got %0d exp 0", done_cnt); end
  endtask

  initial begin
    reset_n = 1'b0;
    w_en = 1'b0; w_addr = '0; w_lane_mask = '0; w_data = '0; r_addr = '0; r_lane = '0; clr_req = 1'b0;
    b_w_en = 1'b0; b_w_addr = '0; b_w_mask = '0; b_w_data = '0; b_r_addr = '0; b_r_lane = '0; b_clr_req = 1'b0;
    test_reset;
    test_write;
    test_bypass;
    test_lane_oob;
    test_clear;
    test_write_busy;
    test_concurrent;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
